// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller and the pipeline registers
// it drives: FSM encodings, the pipeline NOP opcode and the strobe bundle.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hz_state_e;

  localparam logic [6:0] NOP_OP = 7'b0000100;

  typedef struct packed {
    logic stallPc;
    logic stallFd;
    logic stallDx;
    logic flushFd;
    logic flushDx;
    logic stallXm;
  } strobes_t;

  // Canned strobe patterns: freeze everything, insert a D/X bubble, squash F/D+D/X
  localparam strobes_t HOLD_ALL = 6'b111001;
  localparam strobes_t BUBBLE   = 6'b110010;
  localparam strobes_t SQUASH   = 6'b000110;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, redirect flush, data-memory
// wait freeze and halt drain, plus a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int HALT_DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       dec_rs,
  input  logic [2:0]       dec_rt,
  input  logic             dec_rs_used,
  input  logic             dec_rt_used,
  input  logic             dx_wr_en,
  input  logic [2:0]       dx_wr_sel,
  input  logic             dx_is_load,
  input  logic             dx_halt,
  input  logic             x_redirect,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             stall_xm,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);

  hz_state_e   state, nxtState;
  logic [DW-1:0] drainCnt, drainNxt;
  strobes_t    strb;
  logic        loadUse;

  assign loadUse = dx_is_load & dx_wr_en &
                   ((dec_rs_used & (dec_rs == dx_wr_sel)) |
                    (dec_rt_used & (dec_rt == dx_wr_sel)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      drainCnt <= '0;
    end else begin
      state    <= nxtState;
      drainCnt <= drainNxt;
    end
  end

  always_comb begin
    nxtState = state;
    drainNxt = drainCnt;
    strb     = '0;
    unique case (state)
      RUN, MEMWAIT: begin
        if (mem_busy) begin
          // Whole front end frozen; execute keeps presenting any redirect.
          strb     = HOLD_ALL;
          nxtState = MEMWAIT;
        end else begin
          nxtState = RUN;
          if (x_redirect)   strb = SQUASH;
          else if (loadUse) strb = BUBBLE;
          if (dx_halt) begin
            nxtState = DRAIN;
            drainNxt = DW'(HALT_DRAIN);
          end
        end
      end
      DRAIN: begin
        if (mem_busy) begin
          strb = HOLD_ALL;
        end else begin
          strb     = BUBBLE;
          drainNxt = drainCnt - DW'(1);
          if (drainNxt == '0) nxtState = HALTED;
        end
      end
      HALTED: strb = BUBBLE;
      default: nxtState = RUN;
    endcase
  end

  // Strobes read as idle while reset is held, whatever the inputs are doing.
  assign stall_pc = rst_n & strb.stallPc;
  assign stall_fd = rst_n & strb.stallFd;
  assign stall_dx = rst_n & strb.stallDx;
  assign flush_fd = rst_n & strb.flushFd;
  assign flush_dx = rst_n & strb.flushDx;
  assign stall_xm = rst_n & strb.stallXm;
  assign halted   = (state == HALTED);

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_pc),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with a 4-bit counter checks saturation.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] dec_rs, dec_rt, dx_wr_sel;
  logic dec_rs_used, dec_rt_used, dx_wr_en, dx_is_load, dx_halt, x_redirect, mem_busy;

  logic stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, stall_xm, halted;
  logic [15:0] stall_cnt;
  logic stall_pc4, stall_fd4, stall_dx4, flush_fd4, flush_dx4, stall_xm4, halted4;
  logic [3:0] stall_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16), .HALT_DRAIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dx_wr_en(dx_wr_en),
    .dx_wr_sel(dx_wr_sel), .dx_is_load(dx_is_load), .dx_halt(dx_halt),
    .x_redirect(x_redirect), .mem_busy(mem_busy), .stall_pc(stall_pc),
    .stall_fd(stall_fd), .stall_dx(stall_dx), .flush_fd(flush_fd),
    .flush_dx(flush_dx), .stall_xm(stall_xm), .halted(halted), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4), .HALT_DRAIN(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dx_wr_en(dx_wr_en),
    .dx_wr_sel(dx_wr_sel), .dx_is_load(dx_is_load), .dx_halt(dx_halt),
    .x_redirect(x_redirect), .mem_busy(mem_busy), .stall_pc(stall_pc4),
    .stall_fd(stall_fd4), .stall_dx(stall_dx4), .flush_fd(flush_fd4),
    .flush_dx(flush_dx4), .stall_xm(stall_xm4), .halted(halted4), .stall_cnt(stall_cnt4)
  );

  // Strobe vector order: {stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, stall_xm, halted}
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] BUBL = 7'b1100100;
  localparam logic [6:0] SQSH = 7'b0001100;
  localparam logic [6:0] HOLD = 7'b1110010;
  localparam logic [6:0] HALT = 7'b1100101;

  typedef struct {
    string       tag;
    logic [6:0]  strb;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int nCmp = 0;
  int nMis = 0;

  logic [6:0] obs, obs4;
  assign obs  = {stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, stall_xm, halted};
  assign obs4 = {stall_pc4, stall_fd4, stall_dx4, flush_fd4, flush_dx4, stall_xm4, halted4};

  task automatic clr();
    dec_rs = 3'd0; dec_rt = 3'd0; dec_rs_used = 1'b0; dec_rt_used = 1'b0;
    dx_wr_en = 1'b0; dx_wr_sel = 3'd0; dx_is_load = 1'b0; dx_halt = 1'b0;
    x_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic setLoad(input logic [2:0] rs, input logic [2:0] rt,
                         input logic rsU, input logic rtU);
    dx_is_load = 1'b1; dx_wr_en = 1'b1; dx_wr_sel = 3'd3;
    dec_rs = rs; dec_rt = rt; dec_rs_used = rsU; dec_rt_used = rtU;
  endtask

  // Queue the expectation for the current input cycle, then check at the falling edge.
  task automatic cyc(input string tag, input logic [6:0] s, input int c);
    exp_t e;
    e.tag  = tag;
    e.strb = s;
    e.cnt  = 16'(c);
    e.cnt4 = 4'((c > 15) ? 15 : c);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    nCmp++;
    assert (obs === e.strb) else begin
      nMis++; $error("FAIL %s strobes: got %b want %b", e.tag, obs, e.strb);
    end
    nCmp++;
    assert (stall_cnt === e.cnt) else begin
      nMis++; $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, stall_cnt, e.cnt);
    end
    nCmp++;
    assert (obs4 === e.strb) else begin
      nMis++; $error("FAIL %s strobes(cnt4): got %b want %b", e.tag, obs4, e.strb);
    end
    nCmp++;
    assert (stall_cnt4 === e.cnt4) else begin
      nMis++; $error("FAIL %s stall_cnt4: got %0d want %0d", e.tag, stall_cnt4, e.cnt4);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    cyc("reset", IDLE, 0);
    rst_n = 1'b1;
    cyc("idle", IDLE, 0);

    // Load-use on Rs, then on Rt, and a non-hazard with Rs unused
    setLoad(3'd3, 3'd1, 1'b1, 1'b0);  cyc("lu_rs", BUBL, 0);
    clr();                            cyc("lu_rs_once", IDLE, 1);
    setLoad(3'd3, 3'd1, 1'b0, 1'b0);  cyc("lu_unused", IDLE, 1);
    setLoad(3'd5, 3'd3, 1'b1, 1'b1);  cyc("lu_rt", BUBL, 1);
    setLoad(3'd3, 3'd3, 1'b1, 1'b1);  dx_wr_en = 1'b0; cyc("lu_nowr", IDLE, 2);
    setLoad(3'd3, 3'd3, 1'b1, 1'b1);  dx_is_load = 1'b0; cyc("lu_noload", IDLE, 2);

    // Redirect beats load-use
    setLoad(3'd3, 3'd0, 1'b1, 1'b0);  x_redirect = 1'b1; cyc("redir_lu", SQSH, 2);
    clr();                            cyc("redir_done", IDLE, 2);

    // Memory wait: 4 busy cycles, redirect arrives on the 2nd and is held
    mem_busy = 1'b1;                  cyc("mw1", HOLD, 2);
    x_redirect = 1'b1;                cyc("mw2", HOLD, 3);
                                      cyc("mw3", HOLD, 4);
                                      cyc("mw4", HOLD, 5);
    mem_busy = 1'b0;                  cyc("mw_exit", SQSH, 6);
    clr();                            cyc("mw_after", IDLE, 6);

    // Halt drain: 3 DRAIN cycles (redirect ignored), then HALTED sticky even with mem_busy
    dx_halt = 1'b1;                   cyc("halt_in", IDLE, 6);
    clr();                            cyc("drain1", BUBL, 6);
    x_redirect = 1'b1;                cyc("drain2_redir", BUBL, 7);
    clr();                            cyc("drain3", BUBL, 8);
                                      cyc("halted1", HALT, 9);
    mem_busy = 1'b1;                  cyc("halted_busy", HALT, 10);
    clr(); setLoad(3'd3, 3'd0, 1'b1, 1'b0); x_redirect = 1'b1;
                                      cyc("halted_redir", HALT, 11);

    // Async reset while HALTED
    clr(); rst_n = 1'b0;              cyc("rst_halted", IDLE, 0);
    rst_n = 1'b1;                     cyc("post_rst", IDLE, 0);

    // Drain extended by two busy cycles: 5 DRAIN cycles total
    dx_halt = 1'b1;                   cyc("halt2_in", IDLE, 0);
    clr();                            cyc("d2_1", BUBL, 0);
    mem_busy = 1'b1;                  cyc("d2_2busy", HOLD, 1);
                                      cyc("d2_3busy", HOLD, 2);
    mem_busy = 1'b0;                  cyc("d2_4", BUBL, 3);
                                      cyc("d2_5", BUBL, 4);
                                      cyc("halted2", HALT, 5);

    // Async reset mid-DRAIN lands back in RUN
    rst_n = 1'b0;                     cyc("rst_mid", IDLE, 0);
    rst_n = 1'b1;
    dx_halt = 1'b1;                   cyc("halt3_in", IDLE, 0);
    clr();                            cyc("d3_1", BUBL, 0);
    rst_n = 1'b0;                     cyc("rst_drain", IDLE, 0);
    rst_n = 1'b1;                     cyc("run_again", IDLE, 0);
    setLoad(3'd3, 3'd0, 1'b1, 1'b0);  cyc("run_lu", BUBL, 0);
    clr();                            cyc("run_idle", IDLE, 1);

    // Saturation: 20 busy cycles; the 4-bit instance must stop at 15
    rst_n = 1'b0;                     cyc("rst_sat", IDLE, 0);
    rst_n = 1'b1;
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++)      cyc("sat_busy", HOLD, i);
    mem_busy = 1'b0;                  cyc("sat_end", IDLE, 20);
                                      cyc("sat_hold", IDLE, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
